dds_spi_rx: RTL and testbench

Receive-side endpoint of the 3-wire DDS serial link (FSYNC/SCLK/SDATA): a synchronous-sampling SPI slave that deserialises 16-bit words and decodes them into an AD9833-style register file. Sits on the system clock in simulation benches and loopback builds, observing the `ddsspi` transmitter pins directly. Gives verification and on-chip self-check a cycle-accurate view of exactly what the DDS latched.

---
 rtl/dds_spi_rx_if.sv | 10 +
 rtl/dds_spi_rx.sv | 192 +++++++++++++++++++
 tb/tb_dds_spi_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dds_spi_rx_if.sv
// Serial pins of the 3-wire DDS link (FSYNC/SCLK/SDATA).
// The transmitter drives them; the receive endpoint only observes them.
interface dds_spi_rx_if;
    logic FSYNC;
    logic SCLK;
    logic SDATA;

    modport master (output FSYNC, output SCLK, output SDATA);
    modport slave  (input  FSYNC, input  SCLK, input  SDATA);
endinterface

// File: rtl/dds_spi_rx.sv
// Synchronous-sampling SPI slave for the DDS link: deserialises 16-bit words into an AD9833-style register file.
// Optional partial-frame error pulse is enabled by defining DDS_SPI_RX_FRAME_ERR_EN.
module dds_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dds_spi_rx_if.slave       spi,
    output logic [15:0]       word,
    output logic              word_valid,
    output logic              frame_err,
    output logic [13:0]       ctrl,
    output logic [27:0]       freq0,
    output logic [27:0]       freq1,
    output logic [11:0]       phase0,
    output logic [11:0]       phase1
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    logic [SYNC_STAGES-1:0] fsync_sync, sclk_sync, sdata_sync;
    logic fsync_hist, sclk_hist;
    logic fsync_cur, sclk_cur, sdata_cur;
    logic sclk_fall, fsync_fall, fsync_rise, sdata_q;

    assign fsync_cur = fsync_sync[SYNC_STAGES-1];
    assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
    assign sdata_cur = sdata_sync[SYNC_STAGES-1];

    // FSYNC resets low so a frame already running at reset release never looks like a fresh FSYNC fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_sync <= '0;
            sclk_sync  <= '1;
            sdata_sync <= '0;
            fsync_hist <= 1'b0;
            sclk_hist  <= 1'b1;
            sclk_fall  <= 1'b0;
            fsync_fall <= 1'b0;
            fsync_rise <= 1'b0;
            sdata_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain shifts one stage per clock.
            fsync_sync <= {fsync_sync[SYNC_STAGES-2:0], spi.FSYNC};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], spi.SDATA};
            fsync_hist <= fsync_cur;
            sclk_hist  <= sclk_cur;
            sclk_fall  <= sclk_hist & ~sclk_cur & ~fsync_hist;
            fsync_fall <= fsync_hist & ~fsync_cur;
            fsync_rise <= ~fsync_hist & fsync_cur;
            sdata_q    <= sdata_cur;
        end
    end

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [15:0] shreg_q, shreg_d;
    logic        load;
    logic        pend_q, pend_d, pend_sel_q, pend_sel_d;
    logic [13:0] pend_lsb_q, pend_lsb_d;
    logic [13:0] ctrl_d;
    logic [27:0] freq0_d, freq1_d, fcur, fnew;
    logic [11:0] phase0_d, phase1_d;
`ifdef DDS_SPI_RX_FRAME_ERR_EN
    logic        err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        load    = 1'b0;
`ifdef DDS_SPI_RX_FRAME_ERR_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (fsync_fall) begin
                    state_d = SHIFT;
                    count_d = 5'd0;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    shreg_d = {shreg_q[14:0], sdata_q};
                    count_d = (count_q == 5'd16) ? count_q : count_q + 5'd1;
                end
                if (count_d == 5'd16) begin
                    load    = 1'b1;
                    state_d = fsync_rise ? IDLE : HOLD;
                end else if (fsync_rise) begin
                    state_d = IDLE;
`ifdef DDS_SPI_RX_FRAME_ERR_EN
                    err_d   = (count_d != 5'd0);
`endif
                end
            end
            HOLD: begin
                if (fsync_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register-file decode of the word completing this cycle.
    always_comb begin
        ctrl_d     = ctrl;
        freq0_d    = freq0;
        freq1_d    = freq1;
        phase0_d   = phase0;
        phase1_d   = phase1;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        pend_lsb_d = pend_lsb_q;
        fcur       = shreg_d[15] ? freq1 : freq0;
        fnew       = fcur;
        if (load) begin
            unique case (shreg_d[15:14])
                2'b00: begin
                    ctrl_d = shreg_d[13:0];
                    pend_d = 1'b0;
                end
                2'b11: begin
                    if (shreg_d[13]) phase1_d = shreg_d[11:0];
                    else             phase0_d = shreg_d[11:0];
                end
                default: begin
                    if (ctrl[13]) begin
                        if (pend_q && (pend_sel_q == shreg_d[15])) begin
                            fnew   = {shreg_d[13:0], pend_lsb_q};
                            pend_d = 1'b0;
                        end else begin
                            pend_d     = 1'b1;
                            pend_sel_d = shreg_d[15];
                            pend_lsb_d = shreg_d[13:0];
                        end
                    end else if (ctrl[12]) begin
                        fnew = {shreg_d[13:0], fcur[13:0]};
                    end else begin
                        fnew = {fcur[27:14], shreg_d[13:0]};
                    end
                    if (shreg_d[15]) freq1_d = fnew;
                    else             freq0_d = fnew;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shreg_q    <= '0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            pend_lsb_q <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            ctrl       <= '0;
            freq0      <= '0;
            freq1      <= '0;
            phase0     <= '0;
            phase1     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            pend_lsb_q <= pend_lsb_d;
            word_valid <= load;
            if (load) word <= shreg_d;
            ctrl       <= ctrl_d;
            freq0      <= freq0_d;
            freq1      <= freq1_d;
            phase0     <= phase0_d;
            phase1     <= phase1_d;
        end
    end

`ifdef DDS_SPI_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= err_d;
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_dds_spi_rx.sv
// Self-checking bench for dds_spi_rx: directed register-file scenarios plus random frames
// compared against an arithmetic model of the DDS register rules.
module tb_dds_spi_rx;
    localparam int SYNC_STAGES = 3;
    localparam int LAT         = SYNC_STAGES + 2;
`ifdef DDS_SPI_RX_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    dds_spi_rx_if spi ();
    logic [15:0] word;
    logic        word_valid, frame_err;
    logic [13:0] ctrl;
    logic [27:0] freq0, freq1;
    logic [11:0] phase0, phase1;

    dds_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi.slave),
        .word(word), .word_valid(word_valid), .frame_err(frame_err),
        .ctrl(ctrl), .freq0(freq0), .freq1(freq1),
        .phase0(phase0), .phase1(phase1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_err   = 0;

    always @(negedge clk) begin
        if (word_valid) n_valid++;
        if (frame_err)  n_err++;
    end

    // Reference model: register file kept as plain integers.
    int unsigned m_ctrl, m_word;
    int unsigned m_f[2];
    int unsigned m_p[2];
    bit          m_pend;
    int unsigned m_psel, m_plsb;

    task automatic model_reset();
        m_ctrl = 0; m_word = 0; m_f[0] = 0; m_f[1] = 0; m_p[0] = 0; m_p[1] = 0;
        m_pend = 0; m_psel = 0; m_plsb = 0;
    endtask

    task automatic model_word(input int unsigned w);
        int unsigned typ, d14, idx;
        typ = w / 16384;
        d14 = w % 16384;
        m_word = w;
        if (typ == 0) begin
            m_ctrl = d14;
            m_pend = 0;
        end else if (typ == 3) begin
            m_p[(w / 8192) % 2] = w % 4096;
        end else begin
            idx = typ - 1;
            if ((m_ctrl / 8192) % 2 == 1) begin
                if (m_pend && m_psel == idx) begin
                    m_f[idx] = d14 * 16384 + m_plsb;
                    m_pend = 0;
                end else begin
                    m_pend = 1; m_psel = idx; m_plsb = d14;
                end
            end else if ((m_ctrl / 4096) % 2 == 1) begin
                m_f[idx] = d14 * 16384 + m_f[idx] % 16384;
            end else begin
                m_f[idx] = (m_f[idx] / 16384) * 16384 + d14;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".word"},   32'(word),   m_word);
        check({tag, ".ctrl"},   32'(ctrl),   m_ctrl);
        check({tag, ".freq0"},  32'(freq0),  m_f[0]);
        check({tag, ".freq1"},  32'(freq1),  m_f[1]);
        check({tag, ".phase0"}, 32'(phase0), m_p[0]);
        check({tag, ".phase1"}, 32'(phase1), m_p[1]);
    endtask

    task automatic clock_bit(input logic b);
        spi.SDATA = b;
        repeat (4) @(negedge clk);
        spi.SCLK = 1'b0;
        repeat (4) @(negedge clk);
        spi.SCLK = 1'b1;
    endtask

    // Sends the first nbits of w (MSB first) as one frame; checks pulse latency and counts.
    task automatic send_frame(input string tag, input logic [15:0] w, input int nbits, input int gap);
        int v0, e0, lat;
        v0 = n_valid; e0 = n_err; lat = 0;
        @(negedge clk);
        spi.FSYNC = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == 15) begin
                spi.SDATA = w[0];
                repeat (4) @(negedge clk);
                spi.SCLK = 1'b0;
                for (int c = 1; c <= 12; c++) begin
                    @(negedge clk);
                    if (word_valid && lat == 0) lat = c;
                end
                spi.SCLK = 1'b1;
            end else begin
                clock_bit(w[15-i]);
            end
        end
        repeat (4) @(negedge clk);
        spi.FSYNC = 1'b1;
        if (nbits == 16) begin
            check({tag, ".lat"}, 32'(lat), 32'(LAT));
            model_word(32'(w));
            repeat (gap) @(negedge clk);
        end else begin
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (frame_err && lat == 0) lat = c;
            end
            check({tag, ".errlat"}, 32'(lat), ERR_EN ? 32'(LAT) : 32'd0);
            repeat (gap) @(negedge clk);
        end
        check({tag, ".nvalid"}, 32'(n_valid - v0), (nbits == 16) ? 32'd1 : 32'd0);
        check({tag, ".nerr"},   32'(n_err - e0),   (nbits != 16 && ERR_EN) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        int nb, v0, e0;
        spi.FSYNC = 1'b1; spi.SCLK = 1'b1; spi.SDATA = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(word_valid), 32'd0);
        check("rst.err",   32'(frame_err),  32'd0);
        check_regs("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_frame("ctl", 16'h2100, 16, 4);
        check_regs("ctl");

        send_frame("b28a", 16'h2100, 16, 4);
        send_frame("b28b", 16'h50C7, 16, 4);
        check("b28.pending", freq0, 32'h0);
        send_frame("b28c", 16'h4000, 16, 4);
        check("b28.commit", freq0, 32'h00010C7);
        send_frame("b28d", 16'h2000, 16, 4);
        check_regs("b28");

        send_frame("hlb1", 16'h1000, 16, 2);
        send_frame("hlb2", 16'h8123, 16, 2);
        send_frame("hlb3", 16'h0000, 16, 2);
        send_frame("hlb4", 16'h8456, 16, 4);
        check_regs("hlb");

        send_frame("ph0", 16'hC7FF, 16, 2);
        send_frame("ph1", 16'hEABC, 16, 4);
        check("ph.phase0", phase0, 32'h7FF);
        check("ph.phase1", phase1, 32'hABC);

        send_frame("part", 16'h4001, 9, 4);
        check_regs("part");
        send_frame("after", 16'h4001, 16, 4);
        check_regs("after");

        for (int k = 0; k < 48; k++) begin
            w  = 16'($urandom);
            nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
            send_frame("rnd", w, nb, int'($urandom_range(2, 5)));
            check_regs("rnd");
        end

        // Reset in the middle of a frame, released while FSYNC is still low.
        v0 = n_valid; e0 = n_err;
        @(negedge clk);
        spi.FSYNC = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) clock_bit(1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid.valid", 32'(word_valid), 32'd0);
        check("mid.err",   32'(frame_err),  32'd0);
        check_regs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) clock_bit(1'b0);
        spi.FSYNC = 1'b1;
        repeat (12) @(negedge clk);
        check("mid.nvalid", 32'(n_valid - v0), 32'd0);
        check("mid.nerr",   32'(n_err - e0),   32'd0);
        send_frame("post", 16'hC123, 16, 4);
        check_regs("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
